// File: rtl/temporizador_cmp_if.sv
// Bus between the symbol sequencer and the timer/comparator: start/stop
// requests with their run parameters, and the counter status coming back.
interface temporizador_cmp_if #(
  parameter int unsigned WIDTH  = 28,
  parameter int unsigned NUM_CH = 3
);
  logic                      inicio;
  logic                      parar;
  logic                      modo;
  logic [WIDTH-1:0]          limite;
  logic [NUM_CH*WIDTH-1:0]   umbral;
  logic [WIDTH-1:0]          cuenta;
  logic                      ocupado;
  logic [NUM_CH-1:0]         coincide;
  logic                      fin;

  modport master (
    output inicio, parar, modo, limite, umbral,
    input  cuenta, ocupado, coincide, fin
  );

  modport slave (
    input  inicio, parar, modo, limite, umbral,
    output cuenta, ocupado, coincide, fin
  );
endinterface

// File: rtl/temporizador_cmp.sv
// Timer/comparator: one up-counter checked against a latched end limit and
// NUM_CH latched thresholds, with one-shot and periodic modes.
module temporizador_cmp #(
  parameter int unsigned WIDTH  = 28,
  parameter int unsigned NUM_CH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  temporizador_cmp_if.slave bus
);

  localparam int unsigned UW = NUM_CH * WIDTH;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CONTANDO = 1'b1;

  logic [0:0]        estado_q,   estado_d;
  logic [WIDTH-1:0]  cuenta_q,   cuenta_d;
  logic [WIDTH-1:0]  limite_q,   limite_d;
  logic [UW-1:0]     umbral_q,   umbral_d;
  logic              modo_q,     modo_d;
  logic              fin_q,      fin_d;
  logic [NUM_CH-1:0] coincide_q, coincide_d;

  // State and run-parameter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= IDLE;
      cuenta_q   <= '0;
      limite_q   <= '0;
      umbral_q   <= '0;
      modo_q     <= 1'b0;
      fin_q      <= 1'b0;
      coincide_q <= '0;
    end else begin
      estado_q   <= estado_d;
      cuenta_q   <= cuenta_d;
      limite_q   <= limite_d;
      umbral_q   <= umbral_d;
      modo_q     <= modo_d;
      fin_q      <= fin_d;
      coincide_q <= coincide_d;
    end
  end

  // Next state: stop beats start, start beats counting; pulses only on counting edges
  always_comb begin
    estado_d   = estado_q;
    cuenta_d   = cuenta_q;
    limite_d   = limite_q;
    umbral_d   = umbral_q;
    modo_d     = modo_q;
    fin_d      = 1'b0;
    coincide_d = '0;

    if (bus.parar) begin
      estado_d = IDLE;
    end else if (bus.inicio) begin
      estado_d = CONTANDO;
      cuenta_d = '0;
      limite_d = bus.limite;
      umbral_d = bus.umbral;
      modo_d   = bus.modo;
    end else if (estado_q == CONTANDO) begin
      // cuenta never exceeds the limit, so thresholds above it never match
      for (int i = 0; i < int'(NUM_CH); i++) begin
        coincide_d[i] = (cuenta_q == umbral_q[i*WIDTH +: WIDTH]);
      end
      if (cuenta_q == limite_q) begin
        fin_d = 1'b1;
        if (modo_q) begin
          cuenta_d = '0;
        end else begin
          estado_d = IDLE;
        end
      end else begin
        cuenta_d = cuenta_q + WIDTH'(1);
      end
    end
  end

  assign bus.cuenta   = cuenta_q;
  assign bus.ocupado  = (estado_q == CONTANDO);
  assign bus.coincide = coincide_q;
  assign bus.fin      = fin_q;

endmodule

// File: tb/tb_temporizador_cmp.sv
// Directed and random checks of temporizador_cmp against an elapsed-cycle
// reference model (outputs derived from cycles since the accepted start).
module tb_temporizador_cmp;

  localparam int unsigned TW = 8;
  localparam int unsigned NC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  temporizador_cmp_if #(.WIDTH(TW), .NUM_CH(NC)) bus ();

  temporizador_cmp #(.WIDTH(TW), .NUM_CH(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit                 m_run;
  bit                 m_mode;
  longint unsigned    m_n;
  longint unsigned    m_lim;
  longint unsigned    m_thr [NC];
  logic [TW-1:0]      exp_cuenta;
  logic               exp_ocu;
  logic               exp_fin;
  logic [NC-1:0]      exp_coin;

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_n = 0; m_lim = 0;
    for (int i = 0; i < int'(NC); i++) m_thr[i] = 0;
    exp_cuenta = '0; exp_ocu = 0; exp_fin = 0; exp_coin = '0;
  endtask

  // Expected outputs after one active edge, from the request inputs at that edge
  task automatic model_edge();
    longint unsigned per;
    exp_fin  = 0;
    exp_coin = '0;
    if (bus.parar) begin
      m_run   = 0;
      exp_ocu = 0;
    end else if (bus.inicio) begin
      m_lim  = bus.limite;
      m_mode = bus.modo;
      for (int i = 0; i < int'(NC); i++) m_thr[i] = bus.umbral[i*TW +: TW];
      m_run = 1; m_n = 0;
      exp_cuenta = '0; exp_ocu = 1;
    end else if (m_run) begin
      m_n = m_n + 1;
      per = m_lim + 1;
      if (m_mode) begin
        exp_cuenta = TW'(m_n % per);
        exp_fin    = ((m_n % per) == 0);
        for (int i = 0; i < int'(NC); i++)
          exp_coin[i] = (m_thr[i] <= m_lim) && (((m_n - 1) % per) == m_thr[i]);
      end else begin
        exp_cuenta = TW'((m_n > m_lim) ? m_lim : m_n);
        exp_fin    = (m_n == per);
        for (int i = 0; i < int'(NC); i++)
          exp_coin[i] = (m_thr[i] <= m_lim) && ((m_n - 1) == m_thr[i]);
        if (m_n == per) begin
          m_run   = 0;
          exp_ocu = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (bus.cuenta === exp_cuenta) else begin
      miscompares++;
      $error("FAIL %s cuenta observed=%0d expected=%0d t=%0t", tag, bus.cuenta, exp_cuenta, $time);
    end
    vectors++;
    assert (bus.ocupado === exp_ocu) else begin
      miscompares++;
      $error("FAIL %s ocupado observed=%0b expected=%0b t=%0t", tag, bus.ocupado, exp_ocu, $time);
    end
    vectors++;
    assert (bus.fin === exp_fin) else begin
      miscompares++;
      $error("FAIL %s fin observed=%0b expected=%0b t=%0t", tag, bus.fin, exp_fin, $time);
    end
    vectors++;
    assert (bus.coincide === exp_coin) else begin
      miscompares++;
      $error("FAIL %s coincide observed=%b expected=%b t=%0t", tag, bus.coincide, exp_coin, $time);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic set_run(input logic [TW-1:0] lim, input logic md,
                         input logic [TW-1:0] u0, input logic [TW-1:0] u1,
                         input logic [TW-1:0] u2);
    bus.limite = lim;
    bus.modo   = md;
    bus.umbral = {u2, u1, u0};
  endtask

  task automatic start(input string tag);
    bus.inicio = 1'b1;
    tick(tag);
    bus.inicio = 1'b0;
  endtask

  initial begin
    bus.inicio = 1'b0; bus.parar = 1'b0; bus.modo = 1'b0;
    bus.limite = '0;   bus.umbral = '0;
    model_reset();
    #2;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("idle", 2);

    // One-shot, thresholds 3/7/20 with limit 10
    set_run(8'd10, 1'b0, 8'd3, 8'd7, 8'd20);
    start("os_start");
    run("oneshot", 14);

    // Periodic limit 4
    set_run(8'd4, 1'b1, 8'd1, 8'd4, 8'd9);
    start("per_start");
    run("periodic", 17);
    bus.parar = 1'b1; tick("per_stop"); bus.parar = 1'b0;
    run("per_idle", 3);

    // Stop exactly when the count reaches the limit: no fin, count holds
    set_run(8'd6, 1'b0, 8'd6, 8'd0, 8'd2);
    start("stop_start");
    run("stop_cnt", 6);
    bus.parar = 1'b1; tick("stop_edge"); bus.parar = 1'b0;
    run("stop_hold", 4);

    // Start and stop together stays idle
    set_run(8'd9, 1'b0, 8'd1, 8'd2, 8'd3);
    bus.inicio = 1'b1; bus.parar = 1'b1; tick("both"); bus.inicio = 1'b0; bus.parar = 1'b0;
    run("both_idle", 3);

    // Restart mid-run with a new limit
    set_run(8'd12, 1'b0, 8'd5, 8'd6, 8'd7);
    start("rs_a");
    run("rs_cnt", 3);
    set_run(8'd2, 1'b0, 8'd1, 8'd2, 8'd0);
    start("rs_b");
    run("rs_new", 5);

    // Held start keeps the count at zero
    bus.inicio = 1'b1; run("hold_ini", 4); bus.inicio = 1'b0;
    run("hold_rel", 3);

    // Limit 0 one-shot and periodic
    set_run(8'd0, 1'b0, 8'd0, 8'd1, 8'd2);
    start("l0_os");
    run("l0_os", 3);
    set_run(8'd0, 1'b1, 8'd0, 8'd3, 8'd0);
    start("l0_per");
    run("l0_per", 5);
    bus.parar = 1'b1; tick("l0_stop"); bus.parar = 1'b0;

    // Threshold equal to limit pulses together with fin
    set_run(8'd5, 1'b0, 8'd5, 8'd5, 8'd4);
    start("eq_start");
    run("eq", 8);

    // Full-scale limit: no wrap
    set_run(8'hFF, 1'b0, 8'hFF, 8'h80, 8'h00);
    start("max_start");
    run("max", 259);

    // Inputs changed after start are ignored
    set_run(8'd8, 1'b0, 8'd8, 8'd2, 8'd30);
    start("latch_start");
    run("latch_a", 4);
    set_run(8'd2, 1'b1, 8'd0, 8'd1, 8'd1);
    run("latch_b", 8);

    // Reset mid-run at count 5
    set_run(8'd20, 1'b1, 8'd6, 8'd7, 8'd8);
    start("rst_start");
    run("rst_cnt", 5);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run("rst_after", 25);

    // Random requests and parameters, changing every cycle
    for (int k = 0; k < 600; k++) begin
      bus.inicio = ($urandom_range(11) == 0);
      bus.parar  = ($urandom_range(39) == 0);
      bus.modo   = 1'($urandom_range(1));
      bus.limite = ($urandom_range(7) == 0) ? '0 : TW'($urandom_range(20));
      for (int i = 0; i < int'(NC); i++) bus.umbral[i*TW +: TW] = TW'($urandom_range(24));
      tick("random");
    end
    bus.inicio = 1'b0; bus.parar = 1'b0;
    run("tail", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temporizador_cmp.md
# temporizador_cmp

Parametrised timer/comparator for the Morse transmitter timing path. A free-running up-counter is started on command and compared against a latched end limit and `NUM_CH` latched intermediate thresholds. It produces one-cycle match and end pulses and supports one-shot and periodic modes. The symbol sequencer uses it to time dot, dash and gap durations from a single counter instead of separate fixed-width comparators.

## Interface
Parameters:
- `WIDTH`, 28, counter and compare width in bits.
- `NUM_CH`, 3, number of intermediate threshold channels (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `inicio`  in  1  start/restart request, sampled each edge.
- `parar`  in  1  stop request, sampled each edge.
- `modo`  in  1  0 = one-shot, 1 = periodic; latched on accepted start.
- `limite`  in  WIDTH  end count; latched on accepted start.
- `umbral`  in  NUM_CH*WIDTH  channel i threshold at bits [i*WIDTH +: WIDTH]; latched on accepted start.
- `cuenta`  out  WIDTH  current counter value.
- `ocupado`  out  1  high while counting.
- `coincide`  out  NUM_CH  per-channel one-cycle match pulse.
- `fin`  out  1  one-cycle pulse when the counter reaches the limit.

## Operation
- States: IDLE (`ocupado`=0) and CONTANDO (`ocupado`=1). All outputs are registered.
- Per-edge priority: `parar` > `inicio` > counting.
- `parar`=1:
  - `ocupado`<=0.
  - `cuenta` holds its value.
  - No `fin` or `coincide` on that edge, even if a match condition holds.
- `inicio`=1 (and `parar`=0), from any state:
  - `cuenta`<=0, `ocupado`<=1.
  - Latch `limite`, `umbral` and `modo` into internal registers.
  - No pulses on that edge.
  - Restarting while CONTANDO discards the current run.
- CONTANDO, no request:
  - If `cuenta`==limite_reg:
    - `fin`<=1.
    - Periodic: `cuenta`<=0, stays CONTANDO.
    - One-shot: `ocupado`<=0, `cuenta` holds at the limit.
  - Otherwise `cuenta`<=`cuenta`+1.
- `coincide[i]`<=1 on any counting edge (not a `parar`/`inicio` edge) where `ocupado`=1 and `cuenta`==umbral_reg[i].
  - A threshold > limite_reg never matches.
  - Several channels may pulse in the same cycle.
  - A threshold equal to the limit pulses together with `fin`.
- IDLE, no request: all registers hold; `fin`, `coincide` return to 0.
- Counter never wraps, because it resets at the limit. limite = 2^WIDTH−1 is legal.
- Input changes after start have no effect until the next accepted start.

## Timing
- Reset values (asynchronous on `rst_n`=0): `cuenta`=0, `ocupado`=0, `fin`=0, `coincide`=0, latched limit/thresholds/mode=0.
- Release: first active edge after `rst_n` rises is processed normally.
- Reset mid-run aborts immediately; no `fin` is issued.
- Start accepted at edge T:
  - `ocupado` and `cuenta`=0 are visible after T.
  - `cuenta`=k is visible after edge T+k.
  - `fin` is high in the cycle after edge T+L+1 (L = latched limit).
  - One-shot: `ocupado` falls at that same edge T+L+1.
  - `coincide[i]` is high in the cycle after edge T+U_i+1.
- Periodic: `fin` recurs every L+1 cycles. L=0 gives `fin` every cycle after the first.
- `fin` and `coincide` last exactly one cycle, except periodic L=0, where `fin` stays high continuously.
- `inicio` held high restarts every edge, so `cuenta` stays 0 and no pulses occur.

## Test plan
- Reset: assert `rst_n`=0 mid-run at `cuenta`=5 → all outputs 0 immediately; no `fin` after release.
- One-shot: `limite`=10, `umbral`={3,7,20}, `modo`=0, pulse `inicio` at T:
  - `coincide[0]` after T+4, `coincide[1]` after T+8, `coincide[2]` never.
  - `fin` after T+11; `ocupado` low from T+11; `cuenta` holds 10.
- Periodic: `limite`=4, `modo`=1 → `fin` after T+5, T+10, T+15; `cuenta` sequence 0,1,2,3,4,0,…
- Stop/restart priority:
  - `parar` at `cuenta`=6 with `limite`=6 → no `fin`, `cuenta` holds 6.
  - `inicio`+`parar` same edge → stays IDLE.
  - `inicio` at `cuenta`=3 → `cuenta` 0, new limit in effect.
- Edge values:
  - `limite`=0 one-shot → `fin` after T+1.
  - `umbral[0]`=`limite`=5 → `coincide[0]` and `fin` in the same cycle.
  - WIDTH=4, `limite`=15 → counts 0..15, no wrap.
- Latching: change `limite` from 8 to 2 at `cuenta`=4 → `fin` still after T+9.
